// File: rtl/cache_pkg.sv
// Shared types for the cache miss handler: FSM state encoding, memory request payload
// and the performance counter width.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_FILL    = 3'd3,
    ST_WR_REQ  = 3'd4
  } miss_handler_state_e;

  localparam int CACHE_ADDR_W  = 32;
  localparam int CACHE_BLOCK_W = 32;
  localparam int CNT_WIDTH     = 32;

  // Payload widths are fixed here; the handler's ADDR_SIZE/BLOCK_SIZE must match them.
  typedef struct packed {
    logic                     write;
    logic [CACHE_ADDR_W-1:0]  addr;
    logic [CACHE_BLOCK_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/cache_perf_counter.sv
// Hit/miss counters for CPU loads. Only the first IDLE lookup of a load is counted;
// the retry lookup right after a refill is suppressed by the refilled flag.
module cache_perf_counter
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_lookup,
  input  logic                 i_hit,
  input  logic                 i_fill,
  input  logic                 i_idle,
  output logic [CNT_WIDTH-1:0] o_hit_count,
  output logic [CNT_WIDTH-1:0] o_miss_count
);

  logic                 r_refilled;
  logic [CNT_WIDTH-1:0] r_hit_count;
  logic [CNT_WIDTH-1:0] r_miss_count;
  logic                 w_count_en;

  assign w_count_en = i_lookup & ~r_refilled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refilled <= 1'b0;
    end else if (i_fill) begin
      r_refilled <= 1'b1;
    end else if (i_idle) begin
      r_refilled <= 1'b0;
    end
  end

  // Counters wrap naturally at 2**CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_count_en) begin
      if (i_hit) begin
        r_hit_count <= r_hit_count + 1'b1;
      end else begin
        r_miss_count <= r_miss_count + 1'b1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;

endmodule

// File: rtl/cache_miss_handler.sv
// Sequencer between the CPU port and a two-way LRU cache: read-miss refill from memory,
// write-through stores without allocation. CACHE_PERF_COUNTERS_EN adds hit/miss counters.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_SETS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic [BLOCK_SIZE-1:0] req_wdata,
  output logic [BLOCK_SIZE-1:0] req_rdata,
  output logic                  stall,
  output logic [ADDR_SIZE-1:0]  cache_addr,
  output logic                  cache_write_enable,
  output logic [BLOCK_SIZE-1:0] cache_write_data,
  input  logic [BLOCK_SIZE-1:0] cache_read_data,
  input  logic                  cache_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_SIZE-1:0]  mem_req_addr,
  output logic [BLOCK_SIZE-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [BLOCK_SIZE-1:0] mem_resp_data
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
`endif
);

  miss_handler_state_e   r_state;
  miss_handler_state_e   w_state_next;
  logic [BLOCK_SIZE-1:0] r_fill;
  logic                  w_load;
  logic                  w_store;
  mem_req_t              w_mem_req;

  // NUM_SETS only travels with the interface for consistency with the cache instance.
  if (NUM_SETS > 0) begin : g_num_sets_ok
  end

  assign w_load  = req_valid & ~req_write;
  assign w_store = req_valid & req_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Responses arriving in any other state are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill <= '0;
    end else if ((r_state == ST_RD_WAIT) && mem_resp_valid) begin
      r_fill <= mem_resp_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load && !cache_hit) begin
          w_state_next = ST_RD_REQ;
        end else if (w_store) begin
          w_state_next = ST_WR_REQ;
        end
      end
      ST_RD_REQ:  if (mem_req_ready)  w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (mem_resp_valid) w_state_next = ST_FILL;
      ST_FILL:    w_state_next = ST_IDLE;
      ST_WR_REQ:  if (mem_req_ready)  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Memory payload is derived from the held CPU request, so it is stable until accepted.
  always_comb begin
    stall              = 1'b0;
    cache_write_enable = 1'b0;
    cache_write_data   = '0;
    mem_req_valid      = 1'b0;
    w_mem_req          = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_load && !cache_hit) begin
          stall = 1'b1;
        end else if (w_store) begin
          stall              = 1'b1;
          cache_write_enable = cache_hit;
          cache_write_data   = req_wdata;
        end
      end
      ST_RD_REQ: begin
        stall          = 1'b1;
        mem_req_valid  = 1'b1;
        w_mem_req.addr = req_addr;
      end
      ST_RD_WAIT: begin
        stall = 1'b1;
      end
      ST_FILL: begin
        stall              = 1'b1;
        cache_write_enable = 1'b1;
        cache_write_data   = r_fill;
      end
      ST_WR_REQ: begin
        stall           = ~mem_req_ready;
        mem_req_valid   = 1'b1;
        w_mem_req.write = 1'b1;
        w_mem_req.addr  = req_addr;
        w_mem_req.wdata = req_wdata;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign cache_addr    = req_addr;
  assign req_rdata     = cache_read_data;
  assign mem_req_write = w_mem_req.write;
  assign mem_req_addr  = w_mem_req.addr;
  assign mem_req_wdata = w_mem_req.wdata;

`ifdef CACHE_PERF_COUNTERS_EN
  cache_perf_counter u_perf_counter (
    .clk          (clk),
    .rst_n        (rst),
    .i_lookup     ((r_state == ST_IDLE) && w_load),
    .i_hit        (cache_hit),
    .i_fill       (r_state == ST_FILL),
    .i_idle       (r_state == ST_IDLE),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler with a stub cache, a memory model with
// configurable ready/response delays and a per-cycle protocol checker.
module tb_cache_miss_handler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_rdata;
  logic        stall;
  logic [31:0] cache_addr;
  logic        cache_write_enable;
  logic [31:0] cache_write_data;
  logic [31:0] cache_read_data;
  logic        cache_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef CACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_miss_handler #(.ADDR_SIZE(32), .BLOCK_SIZE(32), .NUM_SETS(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_write          (req_write),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_rdata          (req_rdata),
    .stall              (stall),
    .cache_addr         (cache_addr),
    .cache_write_enable (cache_write_enable),
    .cache_write_data   (cache_write_data),
    .cache_read_data    (cache_read_data),
    .cache_hit          (cache_hit),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_write      (mem_req_write),
    .mem_req_addr       (mem_req_addr),
    .mem_req_wdata      (mem_req_wdata),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_data      (mem_resp_data)
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    .hit_count          (hit_count),
    .miss_count         (miss_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Stub cache: small fully associative store keyed by full address.
  logic        c_vld [4] = '{default: 1'b0};
  logic [31:0] c_tag [4] = '{default: 32'h0};
  logic [31:0] c_dat [4] = '{default: 32'h0};
  int          c_next = 0;
  int          c_hit_idx;

  always_comb begin
    cache_hit       = 1'b0;
    cache_read_data = 32'h0;
    c_hit_idx       = -1;
    for (int i = 0; i < 4; i++) begin
      if (c_vld[i] && (c_tag[i] == cache_addr)) begin
        cache_hit       = 1'b1;
        cache_read_data = c_dat[i];
        c_hit_idx       = i;
      end
    end
  end

  always @(posedge clk) begin
    if (cache_write_enable) begin
      if (c_hit_idx >= 0) begin
        c_dat[c_hit_idx] <= cache_write_data;
      end else begin
        c_vld[c_next] <= 1'b1;
        c_tag[c_next] <= cache_addr;
        c_dat[c_next] <= cache_write_data;
        c_next        <= (c_next + 1) % 4;
      end
    end
  end

  // Backing memory indexed by addr[11:8]; holds the latest written value (golden data).
  logic [31:0] mem_arr [16] = '{1: 32'hDEADBEEF, 3: 32'h0BADF00D, default: 32'h0};
  int          ready_delay = 0;
  int          resp_delay  = 0;
  int          r_wait = 0;
  logic        r_pend = 1'b0;
  int          r_cnt = 0;
  logic [31:0] r_rdata = 32'h0;
  logic        man_resp = 1'b0;
  logic [31:0] man_data = 32'h0;

  assign mem_req_ready  = mem_req_valid && (r_wait >= ready_delay);
  assign mem_resp_valid = (r_pend && (r_cnt == 0)) || man_resp;
  assign mem_resp_data  = man_resp ? man_data : r_rdata;

  always @(posedge clk) begin
    if (mem_req_valid && !mem_req_ready) r_wait <= r_wait + 1;
    else r_wait <= 0;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_write) begin
        mem_arr[mem_req_addr[11:8]] <= mem_req_wdata;
      end else begin
        r_pend  <= 1'b1;
        r_cnt   <= resp_delay;
        r_rdata <= mem_arr[mem_req_addr[11:8]];
      end
    end else if (r_pend) begin
      if (r_cnt == 0) r_pend <= 1'b0;
      else r_cnt <= r_cnt - 1;
    end
  end

  // Event counters used by the transaction tasks.
  int n_cwe = 0;
  int n_hs  = 0;
  int n_vld = 0;
  always @(posedge clk) begin
    if (cache_write_enable) n_cwe <= n_cwe + 1;
    if (mem_req_valid && mem_req_ready) n_hs <= n_hs + 1;
    if (mem_req_valid) n_vld <= n_vld + 1;
  end

  // Per-cycle protocol checker.
  logic        p_hold  = 1'b0;
  logic        p_write = 1'b0;
  logic [31:0] p_addr  = 32'h0;
  logic [31:0] p_wdata = 32'h0;

  always @(negedge clk) begin
    chk("cache_addr_follows", cache_addr, req_addr);
    if (rst) begin
      if (!req_valid) begin
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("idle_cache_we", {31'b0, cache_write_enable}, 32'd0);
      end
      if (req_valid && !req_write && !stall)
        chk("load_rdata_golden", req_rdata, mem_arr[req_addr[11:8]]);
      if (cache_write_enable) begin
        if (req_write) begin
          chk("store_we_only_on_hit", {31'b0, cache_hit}, 32'd1);
          chk("store_cache_wdata", cache_write_data, req_wdata);
        end else begin
          chk("fill_cache_wdata", cache_write_data, mem_arr[req_addr[11:8]]);
        end
      end
      if (mem_req_valid) begin
        chk("mem_req_addr", mem_req_addr, req_addr);
        chk("mem_req_write", {31'b0, mem_req_write}, {31'b0, req_write});
        if (req_write) chk("mem_req_wdata", mem_req_wdata, req_wdata);
      end
      if (p_hold) begin
        chk("hold_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("hold_write", {31'b0, mem_req_write}, {31'b0, p_write});
        chk("hold_addr", mem_req_addr, p_addr);
        chk("hold_wdata", mem_req_wdata, p_wdata);
      end
    end
    p_hold  <= rst && mem_req_valid && !mem_req_ready;
    p_write <= mem_req_write;
    p_addr  <= mem_req_addr;
    p_wdata <= mem_req_wdata;
  end

  int exp_hit  = 0;
  int exp_miss = 0;

  task automatic chk_counts();
`ifdef CACHE_PERF_COUNTERS_EN
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
`endif
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_data,
                         input int exp_stall, input int exp_cwe, input int exp_hs);
    int s = 0;
    int c0 = n_cwe;
    int h0 = n_hs;
    bit done = 1'b0;
    logic [31:0] got = 32'h0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    req_wdata = 32'h0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (stall) s++;
      else begin
        done = 1'b1;
        got  = req_rdata;
        chk("load_rdata", req_rdata, exp_data);
      end
    end
    if (!done) chk("load_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("load_stall_cycles", s, exp_stall);
    chk("load_cache_writes", n_cwe - c0, exp_cwe);
    chk("load_mem_requests", n_hs - h0, exp_hs);
    $display("load  addr=%08h data=%08h stall_cycles=%0d", addr, got, s);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int rdy,
                          input int exp_stall, input int exp_cwe, input int exp_vld);
    int s = 0;
    int c0 = n_cwe;
    int h0 = n_hs;
    int v0 = n_vld;
    bit done = 1'b0;
    ready_delay = rdy;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("store_we_cycle0", {31'b0, cache_write_enable}, exp_cwe);
      if (stall) s++;
      else begin
        done = 1'b1;
        chk("store_release_on_handshake", {31'b0, mem_req_valid & mem_req_ready}, 32'd1);
      end
    end
    if (!done) chk("store_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    ready_delay = 0;
    chk("store_stall_cycles", s, exp_stall);
    chk("store_cache_writes", n_cwe - c0, exp_cwe);
    chk("store_mem_writes", n_hs - h0, 32'd1);
    chk("store_req_valid_cycles", n_vld - v0, exp_vld);
    $display("store addr=%08h data=%08h stall_cycles=%0d", addr, data, s);
  endtask

  initial begin
    int c0;
    int h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("reset_cache_we", {31'b0, cache_write_enable}, 32'd0);
    chk_counts();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, then hit.
    do_load(32'h100, 32'hDEADBEEF, 4, 1, 1);
    exp_miss++;
    chk_counts();
    do_load(32'h100, 32'hDEADBEEF, 0, 0, 0);
    exp_hit++;
    chk_counts();

    // Store hit with slow memory, then read back.
    do_store(32'h100, 32'h12345678, 3, 4, 1, 4);
    chk_counts();
    do_load(32'h100, 32'h12345678, 0, 0, 0);
    exp_hit++;
    chk_counts();

    // Store miss: no allocation, so the next load misses.
    do_store(32'h200, 32'hCAFEF00D, 0, 1, 0, 1);
    do_load(32'h200, 32'hCAFEF00D, 4, 1, 1);
    exp_miss++;
    chk_counts();

    // Reset while waiting for a read response; the late response must be ignored.
    resp_delay = 4;
    c0 = n_cwe;
    h0 = n_hs;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h300;
    repeat (3) @(negedge clk);
    chk("rd_wait_stall", {31'b0, stall}, 32'd1);
    chk("rd_wait_req_issued", n_hs - h0, 32'd1);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("async_reset_stall", {31'b0, stall}, 32'd0);
    chk("async_reset_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_hit  = 0;
    exp_miss = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("late_resp_no_cache_write", n_cwe - c0, 32'd0);
    chk("late_resp_not_cached", {31'b0, cache_hit}, 32'd0);
    chk_counts();
    resp_delay = 0;
    do_load(32'h300, 32'h0BADF00D, 4, 1, 1);
    exp_miss++;
    chk_counts();

    // Spurious response while idle.
    c0 = n_cwe;
    man_data = 32'hFFFFFFFF;
    man_resp = 1'b1;
    @(negedge clk);
    chk("spurious_resp_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1;
    man_resp = 1'b0;
    @(posedge clk);
    #1;
    chk("spurious_resp_no_write", n_cwe - c0, 32'd0);
    do_load(32'h100, 32'h12345678, 0, 0, 0);
    exp_hit++;
    do_load(32'h300, 32'h0BADF00D, 0, 0, 0);
    exp_hit++;
    chk_counts();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Sequencing block between the CPU memory port and the two-way LRU cache. It looks up each request in the cache, and on a read miss fetches the block from main memory over a valid/ready port and refills the cache. All writes go through to memory (write-through, no write-allocate), and the CPU is stalled until the access completes. It is the cache's direct upstream driver: it owns the cache's `addr`, `write_enable` and `write_data` inputs and consumes `read_data` and `hit`.

## Interface
- `ADDR_SIZE`, 32, address width.
- `BLOCK_SIZE`, 32, cache block width in bits; one memory beat per block.
- `NUM_SETS`, 16, passed through for consistency checks only.
- `clk  in  1`  sole clock; all state updates on the rising edge.
- `rst  in  1`  reset, asynchronous, active-low (asserted at 0).
- `req_valid  in  1`  CPU request present.
- `req_write  in  1`  1 = store, 0 = load.
- `req_addr  in  ADDR_SIZE`  request address.
- `req_wdata  in  BLOCK_SIZE`  store data.
- `req_rdata  out  BLOCK_SIZE`  load data; valid when `req_valid & !req_write & !stall`.
- `stall  out  1`  CPU must hold its request stable while high.
- `cache_addr  out  ADDR_SIZE`  equals `req_addr` at all times.
- `cache_write_enable  out  1`  cache write strobe.
- `cache_write_data  out  BLOCK_SIZE`  cache write data.
- `cache_read_data  in  BLOCK_SIZE`  cache read data.
- `cache_hit  in  1`  combinational cache hit.
- `mem_req_valid  out  1`, `mem_req_ready  in  1`, `mem_req_write  out  1`, `mem_req_addr  out  ADDR_SIZE`, `mem_req_wdata  out  BLOCK_SIZE`  memory request channel.
- `mem_resp_valid  in  1`, `mem_resp_data  in  BLOCK_SIZE`  memory read response; no backpressure.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ.
- IDLE, no request: `stall=0`, no memory or cache activity.
- IDLE, load hit: `req_rdata=cache_read_data`, `stall=0`; remain in IDLE.
- IDLE, load miss: `stall=1`; go to RD_REQ.
- RD_REQ: `mem_req_valid=1`, `mem_req_write=0`, `mem_req_addr=req_addr`. On `mem_req_ready`, go to RD_WAIT.
- RD_WAIT: on `mem_resp_valid`, capture `mem_resp_data` into the fill register and go to FILL.
- FILL: `cache_write_enable=1` with `cache_write_data` = fill register for exactly one cycle, so the cache allocates into its LRU way. Then return to IDLE, where the retried lookup hits and releases the stall.
- IDLE, store: `stall=1`.
  - If `cache_hit`, pulse `cache_write_enable` with `req_wdata` this cycle only.
  - On a miss, the cache is not written.
  - Go to WR_REQ.
- WR_REQ: `mem_req_valid=1`, `mem_req_write=1`, `mem_req_wdata=req_wdata`. In the handshake cycle (`mem_req_ready=1`), `stall=0` and the next state is IDLE, so the CPU retires the store exactly once.
- `mem_req_*` payload is held stable while `mem_req_valid & !mem_req_ready`.
- `mem_resp_valid` outside RD_WAIT is ignored.
- `cache_write_enable` is never asserted outside IDLE-store-hit and FILL.

## Timing
- Reset values: state IDLE, `stall=0`, `mem_req_valid=0`, `cache_write_enable=0`, fill register 0, `req_rdata` follows the cache (combinational).
- Load hit latency: 0 cycles (no stall).
- Load miss, with ready and response each arriving in their first possible cycle: stall high for cycles 0–3 (IDLE, RD_REQ, RD_WAIT, FILL), low in cycle 4 with data.
- Store with ready in cycle 1: stall high in cycle 0, low in cycle 1.
- Asynchronous reset mid-transaction:
  - state returns to IDLE and `mem_req_valid` drops immediately;
  - the pending request is abandoned;
  - a late response is ignored.
- The request is not re-sampled while stalled; `req_*` changes during a stall are a protocol violation.

## Configuration
- `CACHE_PERF_COUNTERS_EN` defined: adds outputs `hit_count` and `miss_count`, 32 bits each, wrapping, reset to 0.
  - A load counts once, in its first IDLE lookup cycle.
  - The post-FILL retry lookup is not counted; a refilled flag set in FILL and cleared in IDLE suppresses it.
  - Stores are not counted.
- Undefined: the ports and counter logic are absent; behaviour is otherwise identical.

## Structure
- `cache_pkg` holds:
  - the `miss_handler_state_e` enum;
  - the `mem_req_t` struct (write, addr, wdata);
  - a localparam for the counter width (32).
- One sub-module, `cache_perf_counter`, holds the two counters and the refilled flag. It is instantiated only under `CACHE_PERF_COUNTERS_EN`.

## Test plan
- Load 0x100 cold, mem ready and response immediate with 0xDEADBEEF → stall for 4 cycles, `req_rdata=0xDEADBEEF` in cycle 4, one FILL write, `miss_count=1`, `hit_count=0`.
- Repeat load 0x100 → 0 stall cycles, `req_rdata=0xDEADBEEF`, no memory request, `hit_count=1`.
- Store 0x100 ← 0x12345678 with `mem_req_ready` held low 3 cycles → cache written once in cycle 0, `mem_req_*` stable for 4 cycles, stall released in the handshake cycle; a following load returns 0x12345678.
- Store to uncached 0x200 → no `cache_write_enable`, one memory write; a subsequent load of 0x200 misses.
- Assert `rst` low during RD_WAIT, then deliver `mem_resp_valid` after release → state IDLE, `mem_req_valid=0`, response ignored, no cache write.
- Spurious `mem_resp_valid` pulse in IDLE → no state change, no cache write.
